imem_responder_r32i: RTL and testbench

//  Instruction-memory responder on the far side of the RISCV32I PC's ProgAddr bus.

---
 rtl/r32i_pkg.sv | 14 +
 rtl/imem_array_r32i.sv | 42 ++++
 rtl/imem_responder_r32i.sv | 130 +++++++++++++
 tb/tb_imem_responder_r32i.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/r32i_pkg.sv
// Shared definitions for the RV32I instruction-memory responder.
//   NOP_INSTR     : ADDI x0,x0,0, returned whenever no valid instruction is available
//   imem_state_t  : fetch FSM states (IDLE, WAIT, VALID)
package r32i_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        VALID
    } imem_state_t;

endpackage

// File: rtl/imem_array_r32i.sv
// Instruction storage for the responder: DEPTH words of dataW bits.
// Ports:
//   clock  in  rising-edge clock for the write port
//   we     in  write strobe
//   waddr  in  word index written when we=1
//   wdata  in  word written when we=1
//   raddr  in  word index read combinationally
//   rdata  out word at raddr
// The array has no reset so that a reset pulse never disturbs the program image.
module imem_array_r32i #(
   parameter int    dataW     = 32,
   parameter int    DEPTH     = 1024,
   parameter string INIT_FILE = ""
) (
   input  logic                     clock,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [dataW-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [dataW-1:0]         rdata
);

   logic [dataW-1:0] mem [DEPTH];

   // Power-up image: all words start at zero; program words are written
   // through the synchronous load port.
   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem[i] = '0;
      end
   end

   // Synchronous write port used by benches and the boot loader.
   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/imem_responder_r32i.sv
// Instruction-memory responder sitting on the PC's ProgAddr bus.
// Captures the byte address, waits WAIT_CYCLES extra cycles and then presents
// the addressed instruction with InstrValid, or a NOP with AddrFault when the
// address is misaligned or beyond the array.
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   ProgAddr      byte address from the PC
//   LoadEn        program-load write strobe
//   LoadAddr      word index written by the load port
//   LoadData      word written by the load port
//   Instr         fetched instruction (NOP when invalid or faulted)
//   InstrValid    Instr belongs to the captured address
//   AddrFault     qualifies Instr: captured address misaligned or out of range
//   Stall         high unless a valid instruction for the current ProgAddr is shown
module imem_responder_r32i
    import r32i_pkg::*;
#(
    parameter int    dataW       = 32,
    parameter int    DEPTH       = 1024,
    parameter int    WAIT_CYCLES = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [dataW-1:0]         ProgAddr,
    input  logic                     LoadEn,
    input  logic [$clog2(DEPTH)-1:0] LoadAddr,
    input  logic [dataW-1:0]         LoadData,
    output logic [dataW-1:0]         Instr,
    output logic                     InstrValid,
    output logic                     AddrFault,
    output logic                     Stall
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [dataW-3:0] DEPTH_WORDS = (dataW - 2)'(DEPTH);

    imem_state_t      state_q, state_d;
    logic [dataW-1:0] latch_addr, latch_addr_d;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
    logic [dataW-1:0] instr_d;
    logic             valid_d;
    logic             fault_d;

    logic [AW-1:0]    latched_idx;
    logic [dataW-1:0] rd_data;
    logic             addr_bad;
    logic             load_hit;
    logic             start;

    assign latched_idx = latch_addr[2 +: AW];

    imem_array_r32i #(
        .dataW    (dataW),
        .DEPTH    (DEPTH),
        .INIT_FILE(INIT_FILE)
    ) u_array (
        .clock(clock),
        .we   (LoadEn),
        .waddr(LoadAddr),
        .wdata(LoadData),
        .raddr(latched_idx),
        .rdata(rd_data)
    );

    // The full upper word index is compared against DEPTH so that large
    // addresses fault instead of aliasing onto the low index bits.
    assign addr_bad = (latch_addr[1:0] != 2'b00) || (latch_addr[dataW-1:2] >= DEPTH_WORDS);

    // A write to the word being fetched or shown must refetch it so that the
    // post-write contents are what the PC finally sees.
    assign load_hit = LoadEn && (LoadAddr == latched_idx) && (state_q != IDLE);

    assign start = (state_q == IDLE) || (ProgAddr != latch_addr) || load_hit;

    assign Stall = !((state_q == VALID) && (ProgAddr == latch_addr));

    // Next-state and next-output logic; a start overrides every other transition.
    always_comb begin
        state_d      = state_q;
        latch_addr_d = latch_addr;
        wait_cnt_d   = wait_cnt;
        instr_d      = Instr;
        valid_d      = InstrValid;
        fault_d      = AddrFault;

        if (start) begin
            latch_addr_d = ProgAddr;
            wait_cnt_d   = CNT_W'(WAIT_CYCLES);
            valid_d      = 1'b0;
            instr_d      = NOP_INSTR;
            state_d      = WAIT;
        end else if (state_q == WAIT) begin
            if (wait_cnt == '0) begin
                valid_d = 1'b1;
                state_d = VALID;
                if (addr_bad) begin
                    instr_d = NOP_INSTR;
                    fault_d = 1'b1;
                end else begin
                    instr_d = rd_data;
                    fault_d = 1'b0;
                end
            end else begin
                wait_cnt_d = wait_cnt - CNT_W'(1);
            end
        end
    end

    // State and registered outputs; reset aborts any fetch in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            latch_addr <= '0;
            wait_cnt   <= '0;
            Instr      <= NOP_INSTR;
            InstrValid <= 1'b0;
            AddrFault  <= 1'b0;
        end else begin
            state_q    <= state_d;
            latch_addr <= latch_addr_d;
            wait_cnt   <= wait_cnt_d;
            Instr      <= instr_d;
            InstrValid <= valid_d;
            AddrFault  <= fault_d;
        end
    end

endmodule

// File: tb/tb_imem_responder_r32i.sv
// Directed bench for imem_responder_r32i. Expected fetch results are queued when
// an address or load is driven and compared when InstrValid rises.
module tb_imem_responder_r32i;

    localparam int WC    = 1;
    localparam int DEPTH = 1024;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock;
    logic        reset;
    logic [31:0] ProgAddr;
    logic        LoadEn;
    logic [9:0]  LoadAddr;
    logic [31:0] LoadData;
    logic [31:0] Instr;
    logic        InstrValid;
    logic        AddrFault;
    logic        Stall;

    typedef struct packed {
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    exp_t        sb[$];
    int          nChecks = 0;
    int          nFails  = 0;
    logic [31:0] progWords [4];

    imem_responder_r32i #(
        .dataW      (32),
        .DEPTH      (DEPTH),
        .WAIT_CYCLES(WC),
        .INIT_FILE  ("")
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ProgAddr  (ProgAddr),
        .LoadEn    (LoadEn),
        .LoadAddr  (LoadAddr),
        .LoadData  (LoadData),
        .Instr     (Instr),
        .InstrValid(InstrValid),
        .AddrFault (AddrFault),
        .Stall     (Stall)
    );

    // 100 MHz clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one clock and sample 1ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Wait (bounded) for InstrValid, checking the pending-fetch outputs on the
    // way, then pop the scoreboard and compare result and latency.
    task automatic waitValid(input string tag, input int expEdges);
        exp_t exp;
        int   n;
        n = 0;
        while (n < 20) begin
            step();
            n++;
            if (InstrValid === 1'b1) break;
            checkOutput({tag, "_pend_instr"}, Instr, NOP);
            checkOutput({tag, "_pend_stall"}, {31'b0, Stall}, 32'd1);
        end
        exp = sb.pop_front();
        checkOutput({tag, "_valid"}, {31'b0, InstrValid}, 32'd1);
        checkOutput({tag, "_latency"}, n, expEdges);
        checkOutput({tag, "_instr"}, Instr, exp.instr);
        checkOutput({tag, "_fault"}, {31'b0, AddrFault}, {31'b0, exp.fault});
        checkOutput({tag, "_stall"}, {31'b0, Stall}, 32'd0);
    endtask

    // Drive a new fetch address and expect its result 2+WAIT_CYCLES edges later.
    task automatic applyStimulus(input string tag, input logic [31:0] addr,
                                 input logic [31:0] expInstr, input logic expFault);
        ProgAddr = addr;
        sb.push_back('{instr: expInstr, fault: expFault});
        waitValid(tag, 2 + WC);
    endtask

    initial begin
        progWords[0] = 32'h0010_0093;
        progWords[1] = 32'h0020_0113;
        progWords[2] = 32'h0030_0193;
        progWords[3] = 32'h0040_0213;

        reset    = 1'b1;
        ProgAddr = 32'h0;
        LoadEn   = 1'b0;
        LoadAddr = '0;
        LoadData = '0;
        #1;
        checkOutput("rst_instr", Instr, NOP);
        checkOutput("rst_valid", {31'b0, InstrValid}, 32'd0);
        checkOutput("rst_fault", {31'b0, AddrFault}, 32'd0);
        checkOutput("rst_stall", {31'b0, Stall}, 32'd1);

        // Program load while held in reset.
        for (int i = 0; i < 4; i++) begin
            LoadEn   = 1'b1;
            LoadAddr = 10'(i);
            LoadData = progWords[i];
            step();
        end
        LoadEn = 1'b0;
        checkOutput("rst_hold_instr", Instr, NOP);

        // Test 1: first fetch out of reset.
        reset = 1'b0;
        applyStimulus("t1_addr0", 32'h0, progWords[0], 1'b0);

        // Test 2: stepping through sequential words, holding each for a while.
        step();
        step();
        checkOutput("t2_hold_valid", {31'b0, InstrValid}, 32'd1);
        checkOutput("t2_hold_instr", Instr, progWords[0]);
        applyStimulus("t2_addr4", 32'h4, progWords[1], 1'b0);
        step();
        checkOutput("t2_hold4_instr", Instr, progWords[1]);
        applyStimulus("t2_addr8", 32'h8, progWords[2], 1'b0);

        // Test 3: address change mid-WAIT abandons the first fetch.
        applyStimulus("t3_addr0", 32'h0, progWords[0], 1'b0);
        ProgAddr = 32'h4;
        step();
        checkOutput("t3_mid_valid", {31'b0, InstrValid}, 32'd0);
        checkOutput("t3_mid_instr", Instr, NOP);
        applyStimulus("t3_addr8", 32'h8, progWords[2], 1'b0);

        // Test 4: misaligned and out-of-range addresses.
        applyStimulus("t4_misalign", 32'h0000_0006, NOP, 1'b1);
        applyStimulus("t4_depth", DEPTH * 4, NOP, 1'b1);
        applyStimulus("t4_alias", 32'h0000_1008, NOP, 1'b1);
        applyStimulus("t4_top", 32'hFFFF_FFFC, NOP, 1'b1);
        applyStimulus("t4_recover", 32'h8, progWords[2], 1'b0);

        // Test 5: writing the shown word restarts the fetch.
        LoadEn   = 1'b1;
        LoadAddr = 10'd2;
        LoadData = 32'hDEAD_BEEF;
        step();
        LoadEn = 1'b0;
        progWords[2] = 32'hDEAD_BEEF;
        checkOutput("t5_drop_valid", {31'b0, InstrValid}, 32'd0);
        sb.push_back('{instr: progWords[2], fault: 1'b0});
        waitValid("t5_reload", 1 + WC);

        // A write elsewhere leaves the shown word alone.
        LoadEn   = 1'b1;
        LoadAddr = 10'd3;
        LoadData = 32'h0055_0093;
        step();
        LoadEn = 1'b0;
        progWords[3] = 32'h0055_0093;
        checkOutput("t5_other_valid", {31'b0, InstrValid}, 32'd1);
        checkOutput("t5_other_instr", Instr, 32'hDEAD_BEEF);
        applyStimulus("t5_addr12", 32'hC, progWords[3], 1'b0);

        // Test 6: asynchronous reset pulse during WAIT.
        ProgAddr = 32'h0;
        step();
        checkOutput("t6_wait_valid", {31'b0, InstrValid}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6_rst_instr", Instr, NOP);
        checkOutput("t6_rst_valid", {31'b0, InstrValid}, 32'd0);
        checkOutput("t6_rst_fault", {31'b0, AddrFault}, 32'd0);
        checkOutput("t6_rst_stall", {31'b0, Stall}, 32'd1);
        #9;
        reset = 1'b0;
        sb.push_back('{instr: progWords[0], fault: 1'b0});
        waitValid("t6_refetch", 2 + WC);
        applyStimulus("t6_array_kept", 32'h8, 32'hDEAD_BEEF, 1'b0);

        $display("[TB] scoreboard entries left: %0d", sb.size());
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
